// File: rtl/doppler_sweep_ctrl_if.sv
// Purpose: groups the sweep controller's control, settings and core-facing signals.
// Latency: wiring only, no registers.
// Backpressure: none; start is a single-cycle request, abort is a level.
interface doppler_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               start_in;
  logic               abort_in;
  logic [7:0]         dopp_start_in;
  logic [7:0]         dopp_stop_in;
  logic [3:0]         dopp_step_in;
  logic [DWELL_W-1:0] dwell_in;
  logic               epoch_in;
  logic               code_phase_done_in;
  logic [7:0]         doppler_out;
  logic               ca_phase_start_out;
  logic               busy_out;
  logic               done_out;
  logic [7:0]         step_cnt_out;

  // Controller side.
  modport slave (
    input  start_in, abort_in, dopp_start_in, dopp_stop_in, dopp_step_in,
           dwell_in, epoch_in, code_phase_done_in,
    output doppler_out, ca_phase_start_out, busy_out, done_out, step_cnt_out
  );

  // Host / core side driving the controller.
  modport master (
    output start_in, abort_in, dopp_start_in, dopp_stop_in, dopp_step_in,
           dwell_in, epoch_in, code_phase_done_in,
    input  doppler_out, ca_phase_start_out, busy_out, done_out, step_cnt_out
  );
endinterface

// File: rtl/doppler_sweep_ctrl.sv
// Purpose: steps a signed Doppler code from start to stop, dwelling N code epochs per value.
// Latency: start -> alignment pulse next edge; each epoch acts on the following edge.
// Backpressure: none; abort_in returns to IDLE next edge. Macro DOPP_SWEEP_BIDIR_EN enables ping-pong sweeping.
module doppler_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input logic                 clk_in,
  input logic                 rst_in,
  doppler_sweep_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [7:0]         dopp_q, dopp_nxt;
  logic [7:0]         step_cnt_q, step_cnt_nxt;
  logic [DWELL_W-1:0] cnt_q, cnt_nxt;
  logic               ca_q, ca_nxt;
  // Settings captured at start; the start/stop pair swaps in bidirectional mode.
  logic [7:0]         tgt_start_q, tgt_start_nxt;
  logic [7:0]         tgt_stop_q, tgt_stop_nxt;
  logic [3:0]         step_q, step_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic               dir_up_q, dir_up_nxt;

  // One step toward tgt, clamped so it never passes tgt; 9-bit math keeps -128..127 from wrapping.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [3:0] stp,
                                             input logic [7:0] tgt, input logic up);
    logic signed [8:0] c9, t9, s9, n9;
    c9 = $signed({cur[7], cur});
    t9 = $signed({tgt[7], tgt});
    s9 = $signed({5'b00000, stp});
    if (up) begin
      n9 = c9 + s9;
      if (n9 > t9) n9 = t9;
    end else begin
      n9 = c9 - s9;
      if (n9 < t9) n9 = t9;
    end
    return n9[7:0];
  endfunction

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and datapath decisions for the sweep.
  always_comb begin
    state_nxt     = state_q;
    dopp_nxt      = dopp_q;
    step_cnt_nxt  = step_cnt_q;
    cnt_nxt       = cnt_q;
    ca_nxt        = 1'b0;
    tgt_start_nxt = tgt_start_q;
    tgt_stop_nxt  = tgt_stop_q;
    step_nxt      = step_q;
    dwell_nxt     = dwell_q;
    dir_up_nxt    = dir_up_q;
    case (state_q)
      IDLE: begin
        if (sw.start_in && !sw.abort_in) begin
          tgt_start_nxt = sw.dopp_start_in;
          tgt_stop_nxt  = sw.dopp_stop_in;
          step_nxt      = (sw.dopp_step_in == 4'd0) ? 4'd1 : sw.dopp_step_in;
          dwell_nxt     = (sw.dwell_in == '0) ? DWELL_W'(1) : sw.dwell_in;
          dir_up_nxt    = ($signed(sw.dopp_stop_in) >= $signed(sw.dopp_start_in));
          dopp_nxt      = sw.dopp_start_in;
          ca_nxt        = 1'b1;
          step_cnt_nxt  = 8'd0;
          state_nxt     = ALIGN;
        end
      end
      ALIGN: begin
        // The pulse cycle is skipped: a done seen then belongs to an earlier alignment.
        if (sw.abort_in) begin
          state_nxt = IDLE;
        end else if (!ca_q && sw.code_phase_done_in) begin
          cnt_nxt   = dwell_q;
          state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (sw.abort_in) begin
          state_nxt = IDLE;
        end else if (sw.epoch_in) begin
          if (cnt_q <= DWELL_W'(1)) begin
            step_cnt_nxt = step_cnt_q + 8'd1;
            cnt_nxt      = dwell_q;
            if (dopp_q == tgt_stop_q) begin
`ifdef DOPP_SWEEP_BIDIR_EN
              // Turn around without re-dwelling the endpoint.
              tgt_start_nxt = tgt_stop_q;
              tgt_stop_nxt  = tgt_start_q;
              dir_up_nxt    = ~dir_up_q;
              dopp_nxt      = step_toward(dopp_q, step_q, tgt_start_q, ~dir_up_q);
`else
              state_nxt = DONE;
`endif
            end else begin
              dopp_nxt = step_toward(dopp_q, step_q, tgt_stop_q, dir_up_q);
            end
          end else begin
            cnt_nxt = cnt_q - DWELL_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; reset clears outputs and counter, doppler holds on abort.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dopp_q      <= 8'd0;
      step_cnt_q  <= 8'd0;
      cnt_q       <= '0;
      ca_q        <= 1'b0;
      tgt_start_q <= 8'd0;
      tgt_stop_q  <= 8'd0;
      step_q      <= 4'd0;
      dwell_q     <= '0;
      dir_up_q    <= 1'b0;
    end else begin
      dopp_q      <= dopp_nxt;
      step_cnt_q  <= step_cnt_nxt;
      cnt_q       <= cnt_nxt;
      ca_q        <= ca_nxt;
      tgt_start_q <= tgt_start_nxt;
      tgt_stop_q  <= tgt_stop_nxt;
      step_q      <= step_nxt;
      dwell_q     <= dwell_nxt;
      dir_up_q    <= dir_up_nxt;
    end
  end

  assign sw.doppler_out        = dopp_q;
  assign sw.ca_phase_start_out = ca_q;
  assign sw.busy_out           = (state_q != IDLE);
  assign sw.done_out           = (state_q == DONE);
  assign sw.step_cnt_out       = step_cnt_q;

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// Purpose: directed checks of the Doppler sweep controller.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a; every step is a fixed number of cycles.
module tb_doppler_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  doppler_sweep_ctrl_if #(.DWELL_W(16)) sw();

  doppler_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .sw     (sw)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic epoch();
    sw.epoch_in = 1'b1;
    tick();
    sw.epoch_in = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag, input int dopp);
    check({tag, "_dopp"}, $signed(sw.doppler_out), dopp);
    check({tag, "_ca"}, {31'd0, sw.ca_phase_start_out}, 0);
    check({tag, "_busy"}, {31'd0, sw.busy_out}, 0);
    check({tag, "_done"}, {31'd0, sw.done_out}, 0);
  endtask

  // Start, check the alignment pulse, then complete alignment into DWELL.
  task automatic start_sweep(input int s, input int e, input int st, input int dw);
    sw.dopp_start_in = 8'(s);
    sw.dopp_stop_in  = 8'(e);
    sw.dopp_step_in  = 4'(st);
    sw.dwell_in      = 16'(dw);
    sw.start_in      = 1'b1;
    tick();
    sw.start_in = 1'b0;
    check("start_ca", {31'd0, sw.ca_phase_start_out}, 1);
    check("start_busy", {31'd0, sw.busy_out}, 1);
    check("start_dopp", $signed(sw.doppler_out), s);
    check("start_stepcnt", {24'd0, sw.step_cnt_out}, 0);
    sw.code_phase_done_in = 1'b1;
    tick();
    check("align_ca_low", {31'd0, sw.ca_phase_start_out}, 0);
    tick();
    sw.code_phase_done_in = 1'b0;
  endtask

  // One dwell at value v lasting dw epochs; done must rise only after the final one.
  task automatic dwell_check(input int v, input int dw, input bit last);
    check("dwell_dopp", $signed(sw.doppler_out), v);
    for (int i = 0; i < dw; i++) begin
      epoch();
      check("dwell_done", {31'd0, sw.done_out}, (last && (i == dw - 1)) ? 1 : 0);
    end
  endtask

  task automatic finish_sweep(input int dopp, input int cnt);
    check("end_stepcnt", {24'd0, sw.step_cnt_out}, cnt);
    tick();
    check_idle_outputs("after_done", dopp);
  endtask

  initial begin
    sw.start_in           = 1'b0;
    sw.abort_in           = 1'b0;
    sw.dopp_start_in      = 8'd0;
    sw.dopp_stop_in       = 8'd0;
    sw.dopp_step_in       = 4'd0;
    sw.dwell_in           = 16'd0;
    sw.epoch_in           = 1'b0;
    sw.code_phase_done_in = 1'b0;

    #12;
    check_idle_outputs("reset", 0);
    check("reset_stepcnt", {24'd0, sw.step_cnt_out}, 0);
    rst = 1'b0;
    tick();

`ifdef DOPP_SWEEP_BIDIR_EN
    begin
      int bid[10] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1};
      start_sweep(0, 2, 1, 1);
      for (int k = 0; k < 10; k++) dwell_check(bid[k], 1, 1'b0);
      check("bidir_busy", {31'd0, sw.busy_out}, 1);
      sw.abort_in = 1'b1;
      tick();
      sw.abort_in = 1'b0;
      check_idle_outputs("bidir_abort", 0);
    end
`else
    // Alignment: done during the pulse cycle is ignored; epochs in ALIGN do nothing.
    sw.dopp_start_in = 8'hFC;
    sw.dopp_stop_in  = 8'd4;
    sw.dopp_step_in  = 4'd2;
    sw.dwell_in      = 16'd3;
    sw.start_in           = 1'b1;
    sw.code_phase_done_in = 1'b1;
    tick();
    sw.start_in = 1'b0;
    check("al_ca", {31'd0, sw.ca_phase_start_out}, 1);
    check("al_dopp", $signed(sw.doppler_out), -4);
    tick();
    sw.code_phase_done_in = 1'b0;
    check("al_ca_once", {31'd0, sw.ca_phase_start_out}, 0);
    check("al_busy", {31'd0, sw.busy_out}, 1);
    epoch(); epoch(); epoch();
    check("al_no_dwell_dopp", $signed(sw.doppler_out), -4);
    check("al_no_dwell_cnt", {24'd0, sw.step_cnt_out}, 0);
    sw.code_phase_done_in = 1'b1;
    tick();
    sw.code_phase_done_in = 1'b0;
    // -4..4 step 2, 3 epochs each.
    dwell_check(-4, 3, 1'b0);
    dwell_check(-2, 3, 1'b0);
    dwell_check(0, 3, 1'b0);
    dwell_check(2, 3, 1'b0);
    dwell_check(4, 3, 1'b1);
    finish_sweep(4, 5);

    // 0..5 step 2, clamp at 5.
    start_sweep(0, 5, 2, 1);
    dwell_check(0, 1, 1'b0);
    dwell_check(2, 1, 1'b0);
    dwell_check(4, 1, 1'b0);
    dwell_check(5, 1, 1'b1);
    finish_sweep(5, 4);

    // Downward 10..4 step 3; a mid-sweep start with new settings is ignored.
    start_sweep(10, 4, 3, 2);
    dwell_check(10, 2, 1'b0);
    sw.dopp_start_in = 8'd50;
    sw.dopp_stop_in  = 8'd60;
    sw.dopp_step_in  = 4'd9;
    sw.dwell_in      = 16'd7;
    sw.start_in      = 1'b1;
    tick();
    sw.start_in = 1'b0;
    check("mid_start_ca", {31'd0, sw.ca_phase_start_out}, 0);
    dwell_check(7, 2, 1'b0);
    dwell_check(4, 2, 1'b1);
    finish_sweep(4, 3);

    // Zero step and zero dwell behave as 1.
    start_sweep(0, 2, 0, 0);
    dwell_check(0, 1, 1'b0);
    dwell_check(1, 1, 1'b0);
    dwell_check(2, 1, 1'b1);
    finish_sweep(2, 3);

    // Near the positive and negative limits: clamp without 8-bit wrap.
    start_sweep(100, 127, 15, 1);
    dwell_check(100, 1, 1'b0);
    dwell_check(115, 1, 1'b0);
    dwell_check(127, 1, 1'b1);
    finish_sweep(127, 3);
    start_sweep(-120, -128, 15, 1);
    dwell_check(-120, 1, 1'b0);
    dwell_check(-128, 1, 1'b1);
    finish_sweep(-128, 2);

    // start == stop: exactly one dwell.
    start_sweep(-7, -7, 5, 2);
    dwell_check(-7, 2, 1'b1);
    finish_sweep(-7, 1);

    // Full range: 256 dwells, step count wraps to 0.
    start_sweep(-128, 127, 1, 1);
    for (int v = -128; v < 127; v++) dwell_check(v, 1, 1'b0);
    dwell_check(127, 1, 1'b1);
    finish_sweep(127, 0);

    // Abort during the second dwell.
    start_sweep(-4, 4, 2, 3);
    dwell_check(-4, 3, 1'b0);
    epoch();
    sw.abort_in = 1'b1;
    tick();
    sw.abort_in = 1'b0;
    check_idle_outputs("abort", -2);
    tick();
    check("abort_done_later", {31'd0, sw.done_out}, 0);
    check("abort_busy_later", {31'd0, sw.busy_out}, 0);

    // Start together with abort in IDLE stays idle.
    sw.start_in = 1'b1;
    sw.abort_in = 1'b1;
    tick();
    sw.start_in = 1'b0;
    sw.abort_in = 1'b0;
    check_idle_outputs("start_abort", -2);
`endif

    // Asynchronous reset mid-dwell clears outputs without a clock edge.
    start_sweep(0, 5, 2, 1);
    epoch();
    check("pre_rst_dopp", $signed(sw.doppler_out), 2);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst", 0);
    check("async_rst_stepcnt", {24'd0, sw.step_cnt_out}, 0);
    #3 rst = 1'b0;
    sw.code_phase_done_in = 1'b1;
    sw.epoch_in = 1'b1;
    tick();
    tick();
    sw.code_phase_done_in = 1'b0;
    sw.epoch_in = 1'b0;
    check_idle_outputs("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doppler_sweep_ctrl.md
DOPPLER_SWEEP_CTRL -- requirements
Module: doppler_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of dwell_in and the epoch counter.
REQ-002 SHALL have ports (clock and reset first):
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- start_in  input  1  single-cycle sweep start request.
- abort_in  input  1  level; stops the sweep.
- dopp_start_in  input  8  signed two's-complement first Doppler code.
- dopp_stop_in  input  8  signed two's-complement final Doppler code.
- dopp_step_in  input  4  unsigned step magnitude.
- dwell_in  input  DWELL_W  epochs per Doppler value.
- epoch_in  input  1  1 ms code-epoch pulse from the core (start_out).
- code_phase_done_in  input  1  core code-phase alignment complete.
- doppler_out  output  8  Doppler code driven to the core.
- ca_phase_start_out  output  1  single-cycle alignment request to the core.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  single-cycle sweep-complete pulse.
- step_cnt_out  output  8  completed dwells since the last start.

Function
REQ-003 SHALL implement the states IDLE, ALIGN, DWELL and DONE.
REQ-004 In IDLE, when start_in=1 and abort_in=0, the block SHALL, on the next edge: latch all dopp_*/dwell inputs; set doppler_out=dopp_start_in; set ca_phase_start_out=1 for exactly one cycle; clear step_cnt_out; enter ALIGN.
REQ-005 start_in outside IDLE SHALL be ignored. Latched settings SHALL NOT change mid-sweep.
REQ-006 ALIGN SHALL ignore code_phase_done_in during the ca_phase_start_out cycle. On the first later cycle with code_phase_done_in=1, it SHALL enter DWELL with the epoch counter loaded with dwell.
REQ-007 A dwell value of 0 SHALL be treated as 1. A step value of 0 SHALL be treated as 1.
REQ-008 In DWELL, each epoch_in=1 SHALL decrement the counter. The epoch that takes the counter from 1 to 0 ends the dwell and SHALL increment step_cnt_out, wrapping from 255 to 0.
REQ-009 Direction SHALL be up if dopp_stop >= dopp_start (signed compare), otherwise down.
REQ-010 At dwell end with doppler_out != stop, on the next edge:
- doppler_out SHALL become doppler_out ± step.
- If that value passes stop, doppler_out SHALL clamp to stop.
- The counter SHALL reload and the block SHALL stay in DWELL.
- Arithmetic SHALL be 9-bit signed so that no wrap occurs.
REQ-011 At dwell end with doppler_out == stop, the block SHALL enter DONE. DONE SHALL assert done_out for one cycle and then return to IDLE. doppler_out SHALL hold its last value.
REQ-012 start == stop SHALL produce exactly one dwell and then DONE.
REQ-013 abort_in=1 in ALIGN or DWELL SHALL force IDLE on the next edge, with no done_out pulse and doppler_out held.
REQ-014 abort_in=1 together with start_in=1 in IDLE SHALL keep the block in IDLE.

Reset
REQ-015 rst_in=1 SHALL immediately (asynchronously) force:
- state IDLE;
- doppler_out=0, ca_phase_start_out=0, busy_out=0, done_out=0, step_cnt_out=0;
- the counter to 0.
REQ-016 Reset asserted mid-sweep SHALL discard the sweep. After release, the block SHALL wait for a fresh start_in.

Configuration
REQ-017 Macro DOPP_SWEEP_BIDIR_EN.
- Defined: at dwell end with doppler_out == stop, the block SHALL swap its internal start/stop targets, invert direction and continue in DWELL. It SHALL NOT re-dwell the endpoint, SHALL never enter DONE, and SHALL run until abort_in or reset.
- Undefined: behaviour SHALL follow REQ-011 (single pass).

Verification
REQ-018 start=-4, stop=4, step=2, dwell=3 -> doppler_out -4,-2,0,2,4, each held 3 epochs; done_out pulses after the 15th epoch; step_cnt_out=5.
REQ-019 start=0, stop=5, step=2, dwell=1 -> doppler_out 0,2,4,5 (clamp), then done_out.
REQ-020 start=10, stop=4, step=3, dwell=2 -> doppler_out 10,7,4, then done_out.
REQ-021 start_in -> ca_phase_start_out high exactly 1 cycle; with code_phase_done_in held high during the pulse cycle, DWELL is entered only on the following cycle.
REQ-022 abort_in during the 2nd dwell of REQ-018 -> busy_out=0 next cycle, doppler_out=-2 held, no done_out; rst_in mid-dwell -> all outputs 0 immediately.
REQ-023 With DOPP_SWEEP_BIDIR_EN defined, start=0, stop=2, step=1, dwell=1 -> 0,1,2,1,0,1,2..., done_out never asserted.
